// File: rtl/dmem_line_responder.sv
// Line-granular memory responder for the data cache: one 256-bit read or write per
// transaction, acked after LATENCY cycles. Define DMEM_PROTOCOL_CHECK_EN for the err_o checker.
module dmem_line_responder #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         mem_enable_i,
  input  logic         mem_write_i,
  input  logic [31:0]  mem_addr_i,
  input  logic [255:0] mem_data_i,
  output logic [255:0] mem_data_o,
  output logic         mem_ack_o,
  output logic         err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ack_q;
  logic [255:0]       rdata_q;
  logic               wr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [255:0]       wdata_q;
  logic [255:0]       mem_q [DEPTH];

  logic [IDX_W-1:0]   idx_d;
  logic               accept_d;
  logic               done_d;
  logic               unused_addr;

  assign idx_d       = mem_addr_i[5+IDX_W-1:5];
  assign accept_d    = (state_q == S_IDLE) && mem_enable_i;
  assign done_d      = (state_q == S_WAIT) && (cnt_q == '0);
  assign unused_addr = ^{mem_addr_i[31:5+IDX_W], mem_addr_i[4:0]};

  // Request capture: later input changes are ignored for the rest of the transaction.
  always_ff @(posedge clk_i) begin
    if (accept_d) begin
      wr_q    <= mem_write_i;
      idx_q   <= idx_d;
      wdata_q <= mem_data_i;
    end
  end

  // Backing store is never reset; reset forces IDLE, so a pending write is dropped.
  always_ff @(posedge clk_i) begin
    if (done_d && wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mem_enable_i) begin
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            if (!wr_q) begin
              rdata_q <= mem_q[idx_q];
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_data_o = rdata_q;
  assign mem_ack_o  = ack_q;

`ifdef DMEM_PROTOCOL_CHECK_EN
  logic err_q;
  logic viol_d;

  // The initiator must hold the exact request stable until it sees ack.
  always_comb begin
    viol_d = 1'b0;
    if (state_q == S_WAIT) begin
      viol_d = !mem_enable_i || (mem_write_i != wr_q) || (idx_d != idx_q) ||
               (wr_q && (mem_data_i != wdata_q));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (viol_d) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_line_responder.sv
// Self-checking bench for dmem_line_responder: directed cases plus a randomized
// transaction stream against an array model of the memory and the ack timing.
`timescale 1ns/1ps
module tb_dmem_line_responder;

  localparam int DEPTH   = 512;
  localparam int LATENCY = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_enable = 1'b0;
  logic         mem_write = 1'b0;
  logic [31:0]  mem_addr = '0;
  logic [255:0] mem_wdata = '0;
  logic [255:0] mem_rdata;
  logic         mem_ack;
  logic         err;

  dmem_line_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mem_enable_i (mem_enable),
    .mem_write_i  (mem_write),
    .mem_addr_i   (mem_addr),
    .mem_data_i   (mem_wdata),
    .mem_data_o   (mem_rdata),
    .mem_ack_o    (mem_ack),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  int           n_chk = 0;
  int           n_bad = 0;
  logic [255:0] ref_mem [DEPTH];
  logic [255:0] ref_rd = '0;
  logic         ref_err = 1'b0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % DEPTH);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_ack", 256'(mem_ack), 256'(0));
    end
  endtask

  // Called just after an edge; the next edge is E0. Returns just after E0+LATENCY+1.
  task automatic txn(input logic wr, input logic [31:0] a, input logic [255:0] d, input logic hold);
    int           ln;
    logic [255:0] exp_d;
    ln         = line_of(a);
    mem_enable = 1'b1;
    mem_write  = wr;
    mem_addr   = a;
    mem_wdata  = d;
    @(posedge clk); #1;
    for (int k = 1; k <= LATENCY + 1; k++) begin
      @(posedge clk); #1;
      chk(wr ? "wr_ack" : "rd_ack", 256'(mem_ack), 256'(k == LATENCY));
      exp_d = (!wr && k >= LATENCY) ? ref_mem[ln] : ref_rd;
      chk(wr ? "wr_dout" : "rd_dout", mem_rdata, exp_d);
      if (k == LATENCY && !hold) mem_enable = 1'b0;
    end
    chk("err", 256'(err), 256'(ref_err));
    if (wr) ref_mem[ln] = d;
    else    ref_rd = ref_mem[ln];
  endtask

  initial begin
    logic [255:0] d;
    logic [31:0]  a;
    logic         wr, hold;
    int           last_ln;

    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]   = rnd256();
      dut.mem_q[i] = ref_mem[i];
    end
    ref_mem[3]   = {8{32'hA5A5_0003}};
    dut.mem_q[3] = ref_mem[3];

    #2;
    chk("rst_ack", 256'(mem_ack), 256'(0));
    chk("rst_dout", mem_rdata, 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Read latency from a preloaded line.
    txn(1'b0, 32'h0000_0060, '0, 1'b0);
    chk("rd_line3", mem_rdata, {8{32'hA5A5_0003}});
    idle(1);

    // Write line 7, gap, read back through a different byte offset.
    txn(1'b1, 32'h0000_00E0, {8{32'h1234_5678}}, 1'b0);
    idle(1);
    txn(1'b0, 32'h0000_00E4, '0, 1'b0);
    chk("rd_line7", mem_rdata, {8{32'h1234_5678}});

    // Aliasing: 0x4000 wraps to line 0.
    d = rnd256();
    txn(1'b1, 32'h0000_4000, d, 1'b0);
    txn(1'b0, 32'h0000_0000, '0, 1'b0);
    chk("rd_alias", mem_rdata, d);

    // Back-to-back reads with enable held continuously.
    txn(1'b0, 32'h0000_0060, '0, 1'b1);
    txn(1'b0, 32'h0000_00E0, '0, 1'b0);
    idle(1);

    // Reset in the middle of a write to line 2.
    mem_enable = 1'b1; mem_write = 1'b1; mem_addr = 32'h0000_0040; mem_wdata = rnd256();
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) @(posedge clk);
    #1;
    rst = 1'b1;
    mem_enable = 1'b0;
    #1;
    chk("arst_ack", 256'(mem_ack), 256'(0));
    chk("arst_dout", mem_rdata, 256'(0));
    chk("arst_err", 256'(err), 256'(0));
    ref_rd = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(LATENCY + 4);
    txn(1'b0, 32'h0000_0040, '0, 1'b0);

    // Randomized transaction stream.
    last_ln = 7;
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      a  = $urandom;
      if (!wr && $urandom_range(0, 1) == 1) a = (a & ~32'h0000_3FE0) | (32'(last_ln) << 5);
      d    = rnd256();
      hold = (t != 39) && ($urandom_range(0, 3) == 0);
      txn(wr, a, d, hold);
      if (wr) last_ln = line_of(a);
      if (!hold) idle($urandom_range(0, 2));
    end

`ifdef DMEM_PROTOCOL_CHECK_EN
    // Address changes mid-transaction: flag set, data still from the captured line.
    mem_enable = 1'b1; mem_write = 1'b0; mem_addr = 32'h0000_0120;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) @(posedge clk);
    #1;
    mem_addr = 32'h0000_0140;
    @(posedge clk); #1;
    chk("perr_set", 256'(err), 256'(1));
    for (int k = 6; k <= LATENCY; k++) begin
      @(posedge clk); #1;
    end
    chk("perr_ack", 256'(mem_ack), 256'(1));
    chk("perr_data", mem_rdata, ref_mem[9]);
    mem_enable = 1'b0;
    @(posedge clk); #1;
    chk("perr_hold", 256'(err), 256'(1));
    chk("perr_ackoff", 256'(mem_ack), 256'(0));
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_line_responder.md
# dmem_line_responder

- Responder end of the 256-bit line interface that the data cache drives toward main memory.
- Accepts one line read or line write per transaction and returns `mem_ack_o` after a fixed, configurable latency.
- Holds the backing storage array, so the processor-plus-cache system simulates against a realistic slow memory.
- Single outstanding request; no pipelining of transactions.

## Interface

Parameters:
- `DEPTH`, default 512: number of 256-bit lines; power of two, at least 2.
- `LATENCY`, default 10: cycles from request acceptance to ack; at least 1.

Ports:
- `clk_i` in 1: clock, rising-edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `mem_enable_i` in 1: request valid; the initiator holds it high until it samples ack.
- `mem_write_i` in 1: 1 = line write, 0 = line read; sampled with `mem_enable_i`.
- `mem_addr_i` in 32: byte address; bits [4:0] are ignored.
- `mem_data_i` in 256: write line data.
- `mem_data_o` out 256: read line data.
- `mem_ack_o` out 1: transaction complete; one-cycle pulse.
- `err_o` out 1: sticky protocol-violation flag; see Configuration.

## Operation

State machine:
- IDLE:
  - `mem_enable_i`=1 at a rising edge accepts the request.
  - Captures `mem_write_i`, the line index, and `mem_data_i` into internal registers.
  - Loads the counter with `LATENCY`-1, then goes to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0 at an edge, goes to ACK and registers `mem_ack_o`=1.
  - Read: `mem_data_o` is loaded from the array on the same edge.
  - Write: the array line is written on the same edge.
- ACK:
  - `mem_ack_o` is high for exactly this cycle.
  - Next edge returns to IDLE unconditionally with `mem_ack_o`=0.
  - A request is never accepted in ACK.

Addressing and data:
- Line index is `mem_addr_i[5+$clog2(DEPTH)-1:5]`.
- Higher address bits are ignored, so addresses alias and wrap modulo `DEPTH`*32 bytes.
- `mem_data_o` holds the last read line until the next read completes.
- Writes never change `mem_data_o`.
- Inputs are don't-care in WAIT/ACK; the captured copies are used.

Boundary cases:
- `mem_enable_i` still high in the first IDLE cycle after ACK is accepted as a new request. The initiator must drop enable on the edge that samples ack.
- Reset asserted in WAIT aborts the transaction: no array write, no ack.
- Array contents are not reset. The bench preloads them hierarchically and they survive `rst_i`.

## Timing

- Request sampled at edge E0.
- `mem_ack_o` rises after edge E0+`LATENCY` and falls after edge E0+`LATENCY`+1.
- Read data is valid in the same cycle as ack.
- The write is visible to a read accepted at or after edge E0+`LATENCY`+1.
- Minimum request-to-request spacing: `LATENCY`+2 edges.
- Reset values: state IDLE, counter 0, `mem_ack_o`=0, `mem_data_o`=0, `err_o`=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Counter width is `$clog2(LATENCY+1)`.

## Configuration

Macro `DMEM_PROTOCOL_CHECK_EN`.

Defined:
- In WAIT, each cycle is checked against the captured request:
  - `mem_enable_i`=0,
  - `mem_write_i` differs,
  - the line index differs, or
  - for writes, `mem_data_i` differs.
- Any of these sets `err_o`=1 at the next edge.
- `err_o` stays set until `rst_i`.
- The transaction itself still completes normally from the captured values.

Not defined:
- `err_o` is tied to 0.
- No comparison logic or captured-input comparison is synthesized.

## Test plan

- Read latency: `LATENCY`=10, preload line 3 = {8{32'hA5A5_0003}}, read addr 0x60 at E0. Expect ack only in the cycle after E10, `mem_data_o` = preload in that cycle, ack low after E11.
- Write then read: write line 7 = all 0x1234_5678 (addr 0xE0). After ack, drop enable one cycle, then read 0xE4. Expect the written line and identical ack timing.
- Aliasing: `DEPTH`=512, write addr 0x0000_4000 (wraps to line 0). Read addr 0x0. Expect the written data.
- Back-to-back: hold `mem_enable_i` high continuously for two reads. Expect acks at E10 and E22, and `mem_data_o` updates only at each ack.
- Reset mid-write: assert `rst_i` at E5 of a write to line 2. Expect no ack, line 2 unchanged on a later read, and all outputs at reset values immediately, asynchronously.
- With `DMEM_PROTOCOL_CHECK_EN`: change `mem_addr_i` at E4 of a read. Expect `err_o`=1 after E5 and still 1 after the ack; the data returned is from the original line.
